// File: rtl/rob_multi_wb.sv
// rtl/rob_multi_wb.sv - parametrised reorder buffer with multi-channel writeback, operand lookup and flush
// Optional feature macro: ROB_WB_BYPASS_EN forwards same-cycle writebacks to the lookup ports.
module rob_multi_wb #(
  parameter int DEPTH   = 32,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int NUM_WB  = 2,
  parameter int NUM_LKP = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic [2:0]               disp_op_type_i,
  input  logic [4:0]               disp_rd_addr_i,
  input  logic [31:0]              disp_pc_i,
  input  logic [31:0]              disp_inst_i,
  output logic [IDX_W-1:0]         disp_rob_idx_o,
  input  logic [NUM_WB-1:0]        wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0]  wb_rob_idx_i,
  input  logic [NUM_WB*32-1:0]     wb_data_i,
  input  logic [NUM_LKP*IDX_W-1:0] lkp_idx_i,
  output logic [NUM_LKP-1:0]       lkp_ready_o,
  output logic [NUM_LKP*32-1:0]    lkp_data_o,
  output logic                     commit_valid_o,
  output logic                     commit_regf_we_o,
  output logic [4:0]               commit_rd_addr_o,
  output logic [31:0]              commit_data_o,
  output logic [IDX_W-1:0]         commit_rob_idx_o,
  output logic [31:0]              commit_pc_o,
  output logic [31:0]              commit_inst_o,
  output logic [IDX_W:0]           count_o
);

  localparam logic [1:0]     ST_EMPTY = 2'd0;
  localparam logic [1:0]     ST_WAIT  = 2'd1;
  localparam logic [1:0]     ST_DONE  = 2'd2;
  localparam logic [IDX_W:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;

  // Per-entry storage, packed so each field can be cleared as one vector.
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0][1:0]   status_q;
  logic [DEPTH-1:0][2:0]   op_q;
  logic [DEPTH-1:0][4:0]   rd_q;
  logic [DEPTH-1:0][31:0]  data_q;
  logic [DEPTH-1:0][31:0]  pc_q;
  logic [DEPTH-1:0][31:0]  inst_q;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             disp_fire;

  logic [IDX_W-1:0] wb_idx  [NUM_WB];
  logic [31:0]      wb_dat  [NUM_WB];
  logic [IDX_W-1:0] lkp_idx [NUM_LKP];

  // op_type is kept for debug visibility only; nothing downstream consumes it yet.
  logic op_unused;
  assign op_unused = ^op_q;

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
    assign wb_idx[k] = wb_rob_idx_i[k*IDX_W +: IDX_W];
    assign wb_dat[k] = wb_data_i[k*32 +: 32];
  end

  for (genvar j = 0; j < NUM_LKP; j++) begin : g_lkp
    assign lkp_idx[j] = lkp_idx_i[j*IDX_W +: IDX_W];
  end

  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Ready looks only at registered occupancy, so a same-cycle commit never frees a slot early.
  assign disp_ready_o   = !full && !flush_i;
  assign disp_fire      = disp_valid_i && disp_ready_o;
  assign disp_rob_idx_o = tail_idx;

  assign commit_valid_o   = valid_q[head_idx] && (status_q[head_idx] == ST_DONE) && !flush_i;
  assign commit_regf_we_o = commit_valid_o && (rd_q[head_idx] != 5'd0);
  assign commit_rd_addr_o = rd_q[head_idx];
  assign commit_data_o    = data_q[head_idx];
  assign commit_rob_idx_o = head_idx;
  assign commit_pc_o      = pc_q[head_idx];
  assign commit_inst_o    = inst_q[head_idx];

  assign count_o = tail_q - head_q;

  // Pointer next-state: flush rewinds both pointers, otherwise each advances on its handshake.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit_valid_o) head_d = head_q + PTR_ONE;
      if (disp_fire)      tail_d = tail_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry updates: writeback (channel 0 applied last so it wins), then commit clear, then allocate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      status_q <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
    end else if (flush_i) begin
      valid_q  <= '0;
      status_q <= '0;
    end else begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_valid_i[k] && valid_q[wb_idx[k]]) begin
          status_q[wb_idx[k]] <= ST_DONE;
          data_q[wb_idx[k]]   <= wb_dat[k];
        end
      end
      if (commit_valid_o) begin
        valid_q[head_idx]  <= 1'b0;
        status_q[head_idx] <= ST_EMPTY;
      end
      if (disp_fire) begin
        valid_q[tail_idx]  <= 1'b1;
        status_q[tail_idx] <= ST_WAIT;
        op_q[tail_idx]     <= disp_op_type_i;
        rd_q[tail_idx]     <= disp_rd_addr_i;
        pc_q[tail_idx]     <= disp_pc_i;
        inst_q[tail_idx]   <= disp_inst_i;
      end
    end
  end

  // Operand lookup from stored state, optionally overridden by a same-cycle writeback.
  always_comb begin
    lkp_ready_o = '0;
    lkp_data_o  = '0;
    for (int j = 0; j < NUM_LKP; j++) begin
      lkp_ready_o[j]         = valid_q[lkp_idx[j]] && (status_q[lkp_idx[j]] == ST_DONE);
      lkp_data_o[j*32 +: 32] = data_q[lkp_idx[j]];
`ifdef ROB_WB_BYPASS_EN
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_valid_i[k] && (wb_idx[k] == lkp_idx[j]) && valid_q[lkp_idx[j]]) begin
          lkp_ready_o[j]         = 1'b1;
          lkp_data_o[j*32 +: 32] = wb_dat[k];
        end
      end
`endif
    end
  end

endmodule
